pdm_ddr_demux_array: RTL and testbench

Multi-line PDM microphone front end. It generates the shared PDM bit clock from the system clock and demultiplexes N_LINES DDR data lines, each shared by two microphones (one per clock phase), into 2·N_LINES single-rate channels. It also packs each channel's bitstream into PACK_BITS-wide words for the downstream CIC/decimation stage. It supersedes the fixed two-microphone, single-line DDR-to-SDR converter with a parametrised line count, programmable sample point, input synchronisation, enable control and word packing.

---
 rtl/pdm_ddr_demux_array.sv | 125 ++++++++++++
 tb/tb_pdm_ddr_demux_array.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_ddr_demux_array.sv
// PDM microphone front end: generates the PDM bit clock, demultiplexes N_LINES DDR data lines
// into 2*N_LINES single-rate channels and packs each channel into PACK_BITS-wide words.
module pdm_ddr_demux_array #(
    parameter int unsigned N_LINES   = 4,
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned SAMPLE_PT = 3,
    parameter int unsigned PACK_BITS = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic [N_LINES-1:0]               i_ddr_data,
    output logic                             o_pdm_clk,
    output logic [2*N_LINES-1:0]             o_sdr_data,
    output logic                             o_frame_valid,
    output logic [2*N_LINES*PACK_BITS-1:0]   o_word_data,
    output logic                             o_word_valid
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned N_CH  = 2 * N_LINES;
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned PCK_W = (PACK_BITS > 1) ? $clog2(PACK_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] A_PT    = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] B_PT    = CNT_W'(HALF + SAMPLE_PT);
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(HALF);
    localparam logic [PCK_W-1:0] PCK_MAX = PCK_W'(PACK_BITS - 1);

    logic [N_LINES-1:0]         r_ds1, r_ds2;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_pdm_clk;
    logic [N_LINES-1:0]         r_cap_a;
    logic [N_CH-1:0]            r_sdr;
    logic                       r_frame_valid;
    logic [N_CH*PACK_BITS-1:0]  r_shift;
    logic [PCK_W-1:0]           r_pack_cnt;
    logic [N_CH*PACK_BITS-1:0]  r_word;
    logic                       r_word_valid;

    logic [CNT_W-1:0]           w_cnt_next;
    logic                       w_cap_a;
    logic                       w_frame;
    logic                       w_word_done;
    logic [N_CH-1:0]            w_sdr_next;
    logic [N_CH*PACK_BITS-1:0]  w_shift_next;

    always_comb begin
        w_cnt_next = '0;
        if (i_en && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_cap_a     = i_en && (r_cnt == A_PT);
        w_frame     = i_en && (r_cnt == B_PT);
        w_word_done = w_frame && (r_pack_cnt == PCK_MAX);

        w_sdr_next = '0;
        for (int l = 0; l < int'(N_LINES); l++) begin
            w_sdr_next[2*l]   = r_cap_a[l];
            w_sdr_next[2*l+1] = r_ds2[l];
        end

        // Each channel shifts toward its MSB so the oldest bit ends up on top.
        w_shift_next = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            for (int j = int'(PACK_BITS) - 1; j > 0; j--) begin
                w_shift_next[c*int'(PACK_BITS)+j] = r_shift[c*int'(PACK_BITS)+j-1];
            end
            w_shift_next[c*int'(PACK_BITS)] = w_sdr_next[c];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ds1         <= '0;
            r_ds2         <= '0;
            r_cnt         <= '0;
            r_pdm_clk     <= 1'b0;
            r_frame_valid <= 1'b0;
            r_word_valid  <= 1'b0;
        end else begin
            r_ds1         <= i_ddr_data;
            r_ds2         <= r_ds1;
            r_cnt         <= w_cnt_next;
            r_pdm_clk     <= i_en && (w_cnt_next < HALF_C);
            r_frame_valid <= w_frame;
            r_word_valid  <= w_word_done;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cap_a    <= '0;
            r_sdr      <= '0;
            r_shift    <= '0;
            r_pack_cnt <= '0;
            r_word     <= '0;
        end else if (!i_en) begin
            // Disabling discards any partial word; published outputs hold.
            r_cap_a    <= '0;
            r_shift    <= '0;
            r_pack_cnt <= '0;
        end else begin
            if (w_cap_a) begin
                r_cap_a <= r_ds2;
            end
            if (w_frame) begin
                r_sdr      <= w_sdr_next;
                r_shift    <= w_shift_next;
                r_pack_cnt <= w_word_done ? '0 : r_pack_cnt + PCK_W'(1);
                if (w_word_done) begin
                    r_word <= w_shift_next;
                end
            end
        end
    end

    assign o_pdm_clk     = r_pdm_clk;
    assign o_sdr_data    = r_sdr;
    assign o_frame_valid = r_frame_valid;
    assign o_word_data   = r_word;
    assign o_word_valid  = r_word_valid;

endmodule

// File: tb/tb_pdm_ddr_demux_array.sv
// Bench for pdm_ddr_demux_array: three instances (default, SAMPLE_PT=0/PACK_BITS=1, PACK_BITS=4)
// checked every cycle against a frame-level reference model built from an input history.
module tb_pdm_ddr_demux_array;

    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;
    localparam int SP_T [3] = '{3, 0, 3};
    localparam int PB_T [3] = '{8, 1, 4};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ddr;

    logic        pdm0, pdm1, pdm2;
    logic [7:0]  sdr0, sdr1, sdr2;
    logic        fv0, fv1, fv2;
    logic [63:0] word0;
    logic [7:0]  word1;
    logic [31:0] word2;
    logic        wv0, wv1, wv2;

    always #5 clk = ~clk;

    pdm_ddr_demux_array #(.N_LINES(4), .CLK_DIV(8), .SAMPLE_PT(3), .PACK_BITS(8)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ddr_data(ddr), .o_pdm_clk(pdm0),
        .o_sdr_data(sdr0), .o_frame_valid(fv0), .o_word_data(word0), .o_word_valid(wv0));
    pdm_ddr_demux_array #(.N_LINES(4), .CLK_DIV(8), .SAMPLE_PT(0), .PACK_BITS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ddr_data(ddr), .o_pdm_clk(pdm1),
        .o_sdr_data(sdr1), .o_frame_valid(fv1), .o_word_data(word1), .o_word_valid(wv1));
    pdm_ddr_demux_array #(.N_LINES(4), .CLK_DIV(8), .SAMPLE_PT(3), .PACK_BITS(4)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ddr_data(ddr), .o_pdm_clk(pdm2),
        .o_sdr_data(sdr2), .o_frame_valid(fv2), .o_word_data(word2), .o_word_valid(wv2));

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  hist [0:8191];
    int          ecnt;
    int          k;
    logic        pdm_e;
    logic [7:0]  sdr_e  [3];
    logic        fv_e   [3];
    logic [63:0] word_e [3];
    logic        wv_e   [3];
    int          fcnt   [3];
    logic [7:0]  fr     [3][8];

    task automatic chk(input string tag, input int i, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    function automatic logic [3:0] dsv(input int e);
        return (e >= 2) ? hist[e-2] : 4'h0;
    endfunction

    task automatic clear_model();
        k = 0;
        pdm_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sdr_e[i] = '0; fv_e[i] = 1'b0; word_e[i] = '0; wv_e[i] = 1'b0; fcnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] a, b;
        logic [7:0] s;
        logic [63:0] w;
        if (rst) begin
            hist[ecnt] = 4'h0;
            clear_model();
        end else begin
            hist[ecnt] = ddr;
            for (int i = 0; i < 3; i++) begin
                fv_e[i] = 1'b0;
                wv_e[i] = 1'b0;
            end
            if (en) begin
                for (int i = 0; i < 3; i++) begin
                    if ((k % CLK_DIV) == HALF + SP_T[i]) begin
                        a = dsv(ecnt - HALF);
                        b = dsv(ecnt);
                        for (int l = 0; l < 4; l++) begin
                            s[2*l] = a[l];
                            s[2*l+1] = b[l];
                        end
                        sdr_e[i] = s;
                        fv_e[i] = 1'b1;
                        fr[i][fcnt[i]] = s;
                        fcnt[i]++;
                        if (fcnt[i] == PB_T[i]) begin
                            w = '0;
                            for (int c = 0; c < 8; c++)
                                for (int j = 0; j < PB_T[i]; j++)
                                    w[c*PB_T[i] + PB_T[i]-1-j] = fr[i][j][c];
                            word_e[i] = w;
                            wv_e[i] = 1'b1;
                            fcnt[i] = 0;
                        end
                    end
                end
                k++;
                pdm_e = (k % CLK_DIV) < HALF;
            end else begin
                k = 0;
                pdm_e = 1'b0;
                for (int i = 0; i < 3; i++) fcnt[i] = 0;
            end
        end
        ecnt++;
    endtask

    task automatic check_all();
        chk("pdm_clk", 0, pdm0, pdm_e);
        chk("pdm_clk", 1, pdm1, pdm_e);
        chk("pdm_clk", 2, pdm2, pdm_e);
        chk("sdr_data", 0, sdr0, sdr_e[0]);
        chk("sdr_data", 1, sdr1, sdr_e[1]);
        chk("sdr_data", 2, sdr2, sdr_e[2]);
        chk("frame_valid", 0, fv0, fv_e[0]);
        chk("frame_valid", 1, fv1, fv_e[1]);
        chk("frame_valid", 2, fv2, fv_e[2]);
        chk("word_data", 0, word0, word_e[0]);
        chk("word_data", 1, word1, word_e[1]);
        chk("word_data", 2, word2, word_e[2]);
        chk("word_valid", 0, wv0, wv_e[0]);
        chk("word_valid", 1, wv1, wv_e[1]);
        chk("word_valid", 2, wv2, wv_e[2]);
    endtask

    task automatic step(input logic [3:0] d, input logic e);
        ddr = d;
        en = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Drives a while pdm_clk is high and b while it is low, optionally checking frame spacing.
    task automatic periods(input logic [3:0] a, input logic [3:0] b, input int n,
                           input bit gap_chk);
        int last = -1;
        for (int c = 0; c < n * CLK_DIV; c++) begin
            step(pdm_e ? a : b, 1'b1);
            if (gap_chk && fv0) begin
                if (last >= 0) chk("frame_gap", 0, 64'(ecnt - last), 64'(CLK_DIV));
                last = ecnt;
            end
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pdm", 0, {pdm0, pdm1, pdm2}, 0);
        chk("rst_async_sdr", 0, {sdr0, sdr1, sdr2}, 0);
        chk("rst_async_valid", 0, {fv0, fv1, fv2, wv0, wv1, wv2}, 0);
        chk("rst_async_word", 0, word0 | 64'(word1) | 64'(word2), 0);
        if (ecnt >= 1) hist[ecnt-1] = 4'h0;
        if (ecnt >= 2) hist[ecnt-2] = 4'h0;
        clear_model();
        step(4'($urandom()), 1'b1);
        step(4'($urandom()), 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        int off;
        int n;
        rst = 1'b0;
        en = 1'b0;
        ddr = 4'h0;
        ecnt = 0;
        clear_model();
        #1 rst = 1'b1;
        #1 check_all();
        for (int i = 0; i < 3; i++) step(4'h0, 1'b0);
        rst = 1'b0;
        step(4'h0, 1'b0);
        step(4'h0, 1'b0);

        // Line 0 high-phase 1, low-phase 0.
        periods(4'b0001, 4'b0000, 10, 1'b1);
        chk("sdr_line0", 0, 64'(sdr0[1:0]), 64'(2'b01));
        // Interleave rule on all four lines.
        periods(4'b1010, 4'b0110, 3, 1'b1);
        chk("sdr_interleave", 0, 64'(sdr0), 64'(8'b0110_1100));

        // Partial word discarded on disable, then a clean 1,0,1,1 word on channel 0.
        for (int i = 0; i < 3; i++) step(4'h0, 1'b0);
        periods(4'b1111, 4'b1111, 2, 1'b0);
        for (int i = 0; i < 5; i++) step(4'($urandom()), 1'b0);
        periods(4'b0001, 4'b0000, 1, 1'b0);
        periods(4'b0000, 4'b0000, 1, 1'b0);
        periods(4'b0001, 4'b0000, 1, 1'b0);
        periods(4'b0001, 4'b0000, 1, 1'b0);
        chk("pb4_word_valid", 2, 64'({wv2, fv2}), 64'(2'b11));
        chk("pb4_word_ch0", 2, 64'(word2[3:0]), 64'(4'b1011));

        // Randomised data with occasional disables and asynchronous resets.
        off = 0;
        for (int i = 0; i < 900; i++) begin
            if (off > 0) begin
                off--;
                step(4'($urandom()), 1'b0);
            end else if ($urandom_range(255) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(63) == 0) off = $urandom_range(10, 1);
                step(4'($urandom()), 1'b1);
            end
        end

        // Reset in mid-period, then latency to the first frame.
        periods(4'b0101, 4'b0011, 1, 1'b0);
        step(4'($urandom()), 1'b1);
        step(4'($urandom()), 1'b1);
        async_reset();
        n = 0;
        do begin
            step(4'($urandom()), 1'b1);
            n++;
        end while (!fv0 && n < 20);
        chk("rst_to_frame", 0, 64'(n), 64'(HALF + SP_T[0] + 1));
        periods(4'($urandom()), 4'($urandom()), 9, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
